// File: rtl/fpu_issue_arbiter.sv
// rtl/fpu_issue_arbiter.sv - round-robin issue arbiter sharing one FPU among NUM_REQ clients
// Optional feature macro: FPU_ARB_STICKY_FLAGS_EN (accrued sticky flag register on acc_flags).
module fpu_issue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*7-1:0]  req_opcode,
  input  logic [NUM_REQ*3-1:0]  req_rm,
  input  logic [NUM_REQ*64-1:0] req_a,
  input  logic [NUM_REQ*64-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [63:0]           rsp_result,
  output logic [3:0]            rsp_flags,
  output logic [3:0]            rsp_cmp,
  output logic [6:0]            fpu_opcode,
  output logic [2:0]            fpu_rounding_mode,
  output logic [63:0]           fpu_operand_a,
  output logic [63:0]           fpu_operand_b,
  input  logic [63:0]           fpu_result,
  input  logic [3:0]            fpu_flags,
  input  logic [3:0]            fpu_cmp,
  input  logic                  flags_clr,
  output logic [3:0]            acc_flags
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]     state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] id;
  logic [CW-1:0]  cnt;
  logic [6:0]     op_opcode;
  logic [2:0]     op_rm;
  logic [63:0]    op_a;
  logic [63:0]    op_b;
  logic [63:0]    res_result;
  logic [3:0]     res_flags;
  logic [3:0]     res_cmp;

  logic           found;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] idx;
  logic           capture;

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign req_ready = (state == S_IDLE && found) ? (NUM_REQ'(1) << grant) : '0;
  assign capture   = (state == S_BUSY) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      id         <= '0;
      cnt        <= '0;
      op_opcode  <= '0;
      op_rm      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res_result <= '0;
      res_flags  <= '0;
      res_cmp    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            op_opcode  <= req_opcode[7*grant +: 7];
            op_rm      <= req_rm[3*grant +: 3];
            op_a       <= req_a[64*grant +: 64];
            op_b       <= req_b[64*grant +: 64];
            id         <= grant;
            last_grant <= grant;
            cnt        <= CW'(LATENCY - 1);
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            res_result <= fpu_result;
            res_flags  <= fpu_flags;
            res_cmp    <= fpu_cmp;
            state      <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fpu_opcode        = op_opcode;
  assign fpu_rounding_mode = op_rm;
  assign fpu_operand_a     = op_a;
  assign fpu_operand_b     = op_b;

  assign rsp_valid  = (state == S_RESP);
  assign rsp_id     = id;
  assign rsp_result = res_result;
  assign rsp_flags  = res_flags;
  assign rsp_cmp    = res_cmp;

`ifdef FPU_ARB_STICKY_FLAGS_EN
  logic [3:0] acc_q;

  // A clear coinciding with a capture keeps only the newly captured flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (capture) begin
      acc_q <= (flags_clr ? 4'b0 : acc_q) | fpu_flags;
    end else if (flags_clr) begin
      acc_q <= '0;
    end
  end

  assign acc_flags = acc_q;
`else
  logic unused_flags_clr;
  logic unused_capture;
  assign unused_flags_clr = flags_clr;
  assign unused_capture   = capture;
  assign acc_flags        = 4'b0;
`endif

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// tb/tb_fpu_issue_arbiter.sv - scoreboard bench for fpu_issue_arbiter with a table-driven FPU model
module tb_fpu_issue_arbiter;
  localparam int N = 4;
  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*7-1:0]  req_opcode;
  logic [N*3-1:0]  req_rm;
  logic [N*64-1:0] req_a;
  logic [N*64-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [63:0]     rsp_result;
  logic [3:0]      rsp_flags;
  logic [3:0]      rsp_cmp;
  logic [6:0]      fpu_opcode;
  logic [2:0]      fpu_rounding_mode;
  logic [63:0]     fpu_operand_a;
  logic [63:0]     fpu_operand_b;
  logic [63:0]     fpu_result;
  logic [3:0]      fpu_flags;
  logic [3:0]      fpu_cmp;
  logic            flags_clr;
  logic [3:0]      acc_flags;

  fpu_issue_arbiter #(.NUM_REQ(N), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rm(req_rm), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_cmp(rsp_cmp),
    .fpu_opcode(fpu_opcode), .fpu_rounding_mode(fpu_rounding_mode),
    .fpu_operand_a(fpu_operand_a), .fpu_operand_b(fpu_operand_b),
    .fpu_result(fpu_result), .fpu_flags(fpu_flags), .fpu_cmp(fpu_cmp),
    .flags_clr(flags_clr), .acc_flags(acc_flags)
  );

  // Per-requester payload and the answer the model FPU gives for exactly that payload.
  logic [6:0]  m_op [N];
  logic [2:0]  m_rm [N];
  logic [63:0] m_a  [N];
  logic [63:0] m_b  [N];
  logic [63:0] m_res[N];
  logic [3:0]  m_fl [N];
  logic [3:0]  m_cm [N];

  always_comb begin
    req_opcode = '0;
    req_rm     = '0;
    req_a      = '0;
    req_b      = '0;
    for (int i = 0; i < N; i++) begin
      req_opcode[7*i +: 7] = m_op[i];
      req_rm[3*i +: 3]     = m_rm[i];
      req_a[64*i +: 64]    = m_a[i];
      req_b[64*i +: 64]    = m_b[i];
    end
  end

  always_comb begin
    fpu_result = 64'hBAD0_BAD0_BAD0_BAD0;
    fpu_flags  = 4'hF;
    fpu_cmp    = 4'hF;
    for (int i = 0; i < N; i++) begin
      if (fpu_opcode == m_op[i] && fpu_rounding_mode == m_rm[i] &&
          fpu_operand_a == m_a[i] && fpu_operand_b == m_b[i]) begin
        fpu_result = m_res[i];
        fpu_flags  = m_fl[i];
        fpu_cmp    = m_cm[i];
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  id;
    logic [63:0] res;
    logic [3:0]  fl;
    logic [3:0]  cm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [N-1:0] g_id[$];
  int g_cyc[$];

  task automatic push_exp(input int id);
    exp_t e;
    e.id  = 2'(id);
    e.res = m_res[id];
    e.fl  = m_fl[id];
    e.cm  = m_cm[id];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && req_ready != '0) begin
      chk("ready_onehot", 64'($onehot(req_ready)), 64'd1);
      g_id.push_back(req_ready);
      g_cyc.push_back(cyc);
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        chk("rsp_result", rsp_result, mon_e.res);
        chk("rsp_flags", 64'(rsp_flags), 64'(mon_e.fl));
        chk("rsp_cmp", 64'(rsp_cmp), 64'(mon_e.cm));
      end
    end
  end

  task automatic check_reset(input string p);
    chk({p, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({p, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({p, "_rsp_id"}, 64'(rsp_id), 64'd0);
    chk({p, "_rsp_result"}, rsp_result, 64'd0);
    chk({p, "_rsp_flags"}, 64'(rsp_flags), 64'd0);
    chk({p, "_rsp_cmp"}, 64'(rsp_cmp), 64'd0);
    chk({p, "_fpu_opcode"}, 64'(fpu_opcode), 64'd0);
    chk({p, "_fpu_rm"}, 64'(fpu_rounding_mode), 64'd0);
    chk({p, "_fpu_a"}, fpu_operand_a, 64'd0);
    chk({p, "_fpu_b"}, fpu_operand_b, 64'd0);
    chk({p, "_acc_flags"}, 64'(acc_flags), 64'd0);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 just after the accept edge.
  task automatic issue(input int id, input bit expect_rsp);
    req_valid[id] = 1'b1;
    if (expect_rsp) push_exp(id);
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sb.size() > 0; t++) @(posedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_two, exp_clr;

  initial begin
    req_valid = '0;
    rsp_ready = 1'b1;
    flags_clr = 1'b0;
    m_op[0] = 7'h51; m_rm[0] = 3'd0; m_a[0] = 64'h3FF8_0000_0000_0000; m_b[0] = 64'h3FF8_0000_0000_0000;
    m_res[0] = 64'h0; m_fl[0] = 4'b0000; m_cm[0] = 4'b0100;
    m_op[1] = 7'h02; m_rm[1] = 3'd1; m_a[1] = 64'hC000_0000_0000_0000; m_b[1] = 64'h4010_0000_0000_0000;
    m_res[1] = 64'hC010_0000_0000_0000; m_fl[1] = 4'b0001; m_cm[1] = 4'b0000;
    m_op[2] = 7'h01; m_rm[2] = 3'd0; m_a[2] = 64'h3FF0_0000_0000_0000; m_b[2] = 64'h4000_0000_0000_0000;
    m_res[2] = 64'h4008_0000_0000_0000; m_fl[2] = 4'b0000; m_cm[2] = 4'b0000;
    m_op[3] = 7'h03; m_rm[3] = 3'd2; m_a[3] = 64'h0123_4567_89AB_CDEF; m_b[3] = 64'h89AB_CDEF_0123_4567;
    m_res[3] = 64'h5555_AAAA_5555_AAAA; m_fl[3] = 4'b0010; m_cm[3] = 4'b0001;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fairness: all requesters valid, grants 0,1,2,3,0 four cycles apart.
    g_id.delete();
    g_cyc.delete();
    for (int k = 0; k < 5; k++) push_exp(k % N);
    req_valid = '1;
    for (int t = 0; t < 60 && g_id.size() < 5; t++) begin
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    chk("fair_count", 64'(g_id.size()), 64'd5);
    for (int k = 0; k < 5 && k < g_id.size(); k++) begin
      chk("fair_order", 64'(g_id[k]), 64'(1 << (k % N)));
      if (k > 0) chk("fair_interval", 64'(g_cyc[k] - g_cyc[k-1]), 64'(L + 2));
    end
    drain();

    // Single op from requester 2 with exact latency.
    req_valid = 4'b0100;
    push_exp(2);
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("single_t0_valid", 64'(rsp_valid), 64'd0);
    chk("single_fpu_op", 64'(fpu_opcode), 64'h01);
    chk("single_fpu_a", fpu_operand_a, 64'h3FF0_0000_0000_0000);
    chk("single_fpu_b", fpu_operand_b, 64'h4000_0000_0000_0000);
    chk("single_busy_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("single_t1_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("single_t2_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1 chk("single_idle", 64'(rsp_valid), 64'd0);

    // Back-pressure: response held while rsp_ready is low, requester 3 waits.
    rsp_ready = 1'b0;
    issue(1, 1'b1);
    for (int t = 0; t < 10 && !rsp_valid; t++) @(negedge clk);
    chk("bp_reached", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1 req_valid = 4'b1000;
    push_exp(3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_id", 64'(rsp_id), 64'd1);
      chk("bp_result", rsp_result, m_res[1]);
      chk("bp_flags", 64'(rsp_flags), 64'(m_fl[1]));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_last_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    chk("bp_idle_valid", 64'(rsp_valid), 64'd0);
    chk("bp_idle_ready", 64'(req_ready), 64'b1000);
    @(posedge clk);
    #1 req_valid = '0;
    drain();

    // Compare pass-through on requester 0.
    issue(0, 1'b1);
    drain();

`ifdef FPU_ARB_STICKY_FLAGS_EN
    exp_two = 4'b0101;
    exp_clr = 4'b1000;
`else
    exp_two = 4'b0000;
    exp_clr = 4'b0000;
`endif
    flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    @(negedge clk);
    chk("acc_clr_idle", 64'(acc_flags), 64'd0);
    @(posedge clk);
    #1;
    m_fl[2] = 4'b0100;
    m_fl[3] = 4'b1000;
    issue(1, 1'b1);
    drain();
    issue(2, 1'b1);
    drain();
    chk("acc_two", 64'(acc_flags), 64'(exp_two));
    issue(3, 1'b1);
    @(posedge clk);
    #1 flags_clr = 1'b1;
    @(posedge clk);
    #1 flags_clr = 1'b0;
    chk("acc_clr_capture", 64'(acc_flags), 64'(exp_clr));
    drain();

    // Reset one cycle after accept discards the op; requester 0 wins afterwards.
    issue(1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_no_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1 req_valid = 4'b0101;
    push_exp(0);
    @(negedge clk);
    chk("mid_next_grant", 64'(req_ready), 64'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    drain();

    chk("final_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
